// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: DIGIT_W bits per clock over WIDTH/DIGIT_W cycles, carry held in a register.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_digit_adder #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT_W:0] dig_d;
  logic [WIDTH-1:0] dig_ext_d, acc_d;

  // Current digit sum; the new digit enters acc from the top so that after N
  // digits the first (least significant) digit has reached bit 0.
  always_comb begin
    dig_d     = {1'b0, a_sh_q[DIGIT_W-1:0]} + {1'b0, b_sh_q[DIGIT_W-1:0]}
              + {{DIGIT_W{1'b0}}, carry_q};
    dig_ext_d = WIDTH'(dig_d[DIGIT_W-1:0]);
    acc_d     = (acc_q >> DIGIT_W) | (dig_ext_d << (WIDTH - DIGIT_W));
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  // Carry into the MSB is recovered as a^b^sum at that bit.
  always_comb begin
    ovf_d = a_sh_q[DIGIT_W-1] ^ b_sh_q[DIGIT_W-1] ^ dig_d[DIGIT_W-1] ^ dig_d[DIGIT_W];
  end
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> DIGIT_W;
          b_sh_q  <= b_sh_q >> DIGIT_W;
          carry_q <= dig_d[DIGIT_W];
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            state_q <= DONE;
            sum_q   <= acc_d;
            cout_q  <= dig_d[DIGIT_W];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: digit-serial (8/2) and single-cycle (8/8) instances vs. a+b+cin.
module tb_serial_digit_adder;
  logic       clk = 1'b0;
  logic       rst, start, cin, sel;
  logic [7:0] a, b;
  logic       st2, st8;
  logic       rdy2, dn2, co2, rdy8, dn8, co8;
  logic [7:0] s2, s8;
  logic       ready_w, done_w, cout_w;
  logic [7:0] sum_w;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  assign st2 = start & ~sel;
  assign st8 = start & sel;
  assign ready_w = sel ? rdy8 : rdy2;
  assign done_w  = sel ? dn8  : dn2;
  assign cout_w  = sel ? co8  : co2;
  assign sum_w   = sel ? s8   : s2;

`ifdef SERIAL_ADDER_OVF_EN
  logic ov2, ov8, ovf_w;
  assign ovf_w = sel ? ov8 : ov2;
`endif

  serial_digit_adder #(.WIDTH(8), .DIGIT_W(2)) dut (
    .clk(clk), .rst(rst), .start(st2), .a(a), .b(b), .cin(cin),
    .ready(rdy2), .done(dn2), .sum(s2), .cout(co2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov2)
`endif
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a), .b(b), .cin(cin),
    .ready(rdy8), .done(dn8), .sum(s8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready_w), 32'd1);
    chk({tag, "_done"},  32'(done_w),  32'd0);
    chk({tag, "_sum"},   32'(sum_w),   32'd0);
    chk({tag, "_cout"},  32'(cout_w),  32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},   32'(ovf_w),   32'd0);
`endif
  endtask

  // One operation on the selected instance; inputs are scrambled after acceptance,
  // and with inj a competing request is pulsed while the first one is running.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit inj, input string tag);
    int         n, lat, pulses;
    logic       rdy_run, rdy_after, ex_ovf;
    logic [8:0] exp;
    n      = sel ? 1 : 4;
    exp    = 9'(av) + 9'(bv) + 9'(cv);
    ex_ovf = (av[7] == bv[7]) && (exp[7] != av[7]);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    lat = 0; pulses = 0; rdy_run = 1'b1; rdy_after = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) rdy_run = ready_w;
      if (done_w) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && i == lat + 1) rdy_after = ready_w;
      start = (inj && i == 2);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (inj && i == 2) begin a = 8'h11; b = 8'h22; end
    end
    chk({tag, "_lat"},      32'(lat),       32'(n + 1));
    chk({tag, "_pulses"},   32'(pulses),    32'd1);
    chk({tag, "_busy"},     32'(rdy_run),   32'd0);
    chk({tag, "_rdyback"},  32'(rdy_after), 32'd1);
    chk({tag, "_sum"},      32'(sum_w),     32'(exp[7:0]));
    chk({tag, "_cout"},     32'(cout_w),    32'(exp[8]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},      32'(ovf_w),     32'(ex_ovf));
`endif
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sel = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_idle_zero("rst2");
    sel = 1'b1;
    #1 chk_idle_zero("rst8");
    rst = 1'b0; sel = 1'b0;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "t2");
    run_op(8'h7F, 8'h01, 1'b1, 1'b0, "t3a");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, "t3b");
    run_op(8'h05, 8'h03, 1'b0, 1'b1, "t4");
    run_op(8'h3C, 8'h5A, 1'b1, 1'b0, "pre5");

    // Abort an operation two cycles into RUN.
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("t5abort");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_w) pulses++;
    end
    chk("t5nodone", 32'(pulses), 32'd0);
    run_op(8'h0A, 8'h05, 1'b0, 1'b0, "t5b");

    for (int i = 0; i < 60; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rnd2");

    @(negedge clk);
    sel = 1'b1;
    run_op(8'hC8, 8'h64, 1'b1, 1'b0, "t6");
    for (int i = 0; i < 200; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rnd8");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
